ml_stage_pipe_ctrl: RTL and testbench

//   Elastic valid/ready sequencer for one combinational ML model stage (e.g. ml_model_stage3).

---
 rtl/ml_stage_pipe_ctrl.sv | 94 +++++++++
 tb/tb_ml_stage_pipe_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/ml_stage_pipe_ctrl.sv
// Elastic valid/ready sequencer around one combinational model stage: R0 feeds the datapath,
// R1..R_PIPE retime its result; latency PIPE+1 edges from capture, full backpressure, bubbles collapse.
module ml_stage_pipe_ctrl #(
  parameter int IN_W  = 125,
  parameter int OUT_W = 86,
  parameter int PIPE  = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [IN_W-1:0]  stg_inp,
  input  logic [OUT_W-1:0] stg_out,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [3:0]       occupancy,
  output logic [CNT_W-1:0] in_count,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [IN_W-1:0]  in_reg;
  logic [OUT_W-1:0] stage_dat [1:PIPE];
  logic [PIPE:0]    vld;
  logic [PIPE:0]    adv;
  logic             accept;
  logic             out_fire;

  // A register advances when some slot downstream of it is empty or the output drains;
  // evaluating it this way keeps adv free of bit-to-bit combinational dependencies.
  always_comb begin
    logic tail_full;
    adv       = '0;
    tail_full = 1'b1;
    for (int k = PIPE; k >= 0; k--) begin
      adv[k]    = vld[k] & (out_ready | ~tail_full);
      tail_full = tail_full & vld[k];
    end
  end

  assign in_ready  = ~flush & (~vld[0] | adv[0]);
  assign accept    = in_valid & in_ready;
  assign out_fire  = vld[PIPE] & out_ready & ~flush;
  assign stg_inp   = in_reg;
  assign out_data  = stage_dat[PIPE];
  assign out_valid = vld[PIPE];
  assign occupancy = 4'($countones(vld));
  assign busy      = |vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld       <= '0;
      in_count  <= '0;
      out_count <= '0;
    end else begin
      if (flush) begin
        vld <= '0;
      end else begin
        vld[0] <= accept | (vld[0] & ~adv[0]);
        for (int k = 1; k <= PIPE; k++) begin
          vld[k] <= adv[k-1] | (vld[k] & ~adv[k]);
        end
      end
      if (accept) begin
        in_count <= in_count + CNT_ONE;
      end
      if (out_fire) begin
        out_count <= out_count + CNT_ONE;
      end
    end
  end

  // Data path carries no reset; contents are meaningless while the matching valid is low.
  always_ff @(posedge clk) begin
    if (accept) begin
      in_reg <= in_data;
    end
    if (adv[0]) begin
      stage_dat[1] <= stg_out;
    end
    for (int k = 2; k <= PIPE; k++) begin
      if (adv[k-1]) begin
        stage_dat[k] <= stage_dat[k-1];
      end
    end
  end

endmodule

// File: tb/tb_ml_stage_pipe_ctrl.sv
// Directed bench for ml_stage_pipe_ctrl with PIPE=2, CNT_W=4 and a pass-through datapath stub.
module tb_ml_stage_pipe_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic [124:0] in_data = '0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [124:0] stg_inp;
  logic [85:0]  stg_out;
  logic [85:0]  out_data;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [3:0]   occupancy;
  logic [3:0]   in_count;
  logic [3:0]   out_count;
  logic         busy;

  int errors = 0;
  int checks = 0;

  assign stg_out = stg_inp[85:0];

  ml_stage_pipe_ctrl #(.IN_W(125), .OUT_W(86), .PIPE(2), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .stg_inp(stg_inp), .stg_out(stg_out),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .occupancy(occupancy), .in_count(in_count), .out_count(out_count), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occupancy: got %0d want 0", occupancy); end
    checks++; if (in_count !== 4'd0) begin errors++; $display("FAIL reset_in_count: got %0d want 0", in_count); end
    checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL reset_out_count: got %0d want 0", out_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; in_data = 125'h1ABC;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL single_in_ready: got %b want 1", in_ready); end
    @(posedge clk); #1 in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_ov_t1: got %b want 0", out_valid); end
    checks++; if (in_count !== 4'd1) begin errors++; $display("FAIL single_in_count: got %0d want 1", in_count); end
    checks++; if (occupancy !== 4'd1) begin errors++; $display("FAIL single_occ: got %0d want 1", occupancy); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_ov_t2: got %b want 0", out_valid); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL single_ov_t3: got %b want 1", out_valid); end
    checks++; if (out_data !== 86'h1ABC) begin errors++; $display("FAIL single_data: got %h want 1abc", out_data); end
    @(posedge clk); #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_ov_t4: got %b want 0", out_valid); end
    checks++; if (out_count !== 4'd1) begin errors++; $display("FAIL single_out_count: got %0d want 1", out_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy: got %b want 0", busy); end
  endtask

  // Streams n consecutive values with out_ready=1, checking order and absence of output bubbles.
  task automatic stream_n(input int n, input string tag);
    int sent = 0;
    int recv = 0;
    bit seen = 1'b0;
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 80 && recv < n; cyc++) begin
      in_valid = (sent < n);
      in_data  = 125'(sent);
      #1;
      if (in_valid) begin
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL %s_in_ready: cycle %0d got %b want 1", tag, cyc, in_ready); end
      end
      if (out_valid === 1'b1) begin
        checks++; if (out_data !== 86'(recv)) begin errors++; $display("FAIL %s_data: got %0h want %0h", tag, out_data, recv); end
        recv++; seen = 1'b1;
      end else if (seen) begin
        errors++; checks++; $display("FAIL %s_bubble: out_valid got 0 want 1 after %0d outputs", tag, recv);
      end
      if (in_valid && in_ready === 1'b1) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (recv != n) begin errors++; $display("FAIL %s_timeout: received %0d want %0d", tag, recv, n); end
  endtask

  task automatic test_stream();
    do_reset();
    stream_n(20, "stream");
    checks++; if (in_count !== 4'd4) begin errors++; $display("FAIL stream_in_count: got %0d want 4", in_count); end
    checks++; if (out_count !== 4'd4) begin errors++; $display("FAIL stream_out_count: got %0d want 4", out_count); end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL stream_occ: got %0d want 0", occupancy); end
  endtask

  task automatic test_backpressure();
    int sent = 0;
    int recv = 0;
    do_reset();
    out_ready = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      in_valid = 1'b1; in_data = 125'(100 + sent);
      #1;
      if (in_ready === 1'b1) sent++;
      @(posedge clk); #1;
    end
    checks++; if (sent != 3) begin errors++; $display("FAIL bp_accepted: got %0d want 3", sent); end
    checks++; if (occupancy !== 4'd3) begin errors++; $display("FAIL bp_occ: got %0d want 3", occupancy); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    for (int cyc = 0; cyc < 3; cyc++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 86'd100) begin errors++; $display("FAIL bp_hold: got v=%b d=%0d want v=1 d=100", out_valid, out_data); end
      @(posedge clk); #1;
    end
    checks++; if (out_count !== 4'd0) begin errors++; $display("FAIL bp_out_count_stall: got %0d want 0", out_count); end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 30 && recv < 5; cyc++) begin
      in_valid = (sent < 5); in_data = 125'(100 + sent);
      #1;
      if (out_valid === 1'b1) begin
        checks++; if (out_data !== 86'(100 + recv)) begin errors++; $display("FAIL bp_data: got %0d want %0d", out_data, 100 + recv); end
        recv++;
      end
      if (in_valid && in_ready === 1'b1) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (recv != 5) begin errors++; $display("FAIL bp_delivered: got %0d want 5", recv); end
    checks++; if (in_count !== 4'd5 || out_count !== 4'd5) begin errors++; $display("FAIL bp_counts: got %0d/%0d want 5/5", in_count, out_count); end
  endtask

  task automatic test_flush();
    int waited = 0;
    do_reset();
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 125'(200 + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (occupancy !== 4'd3) begin errors++; $display("FAIL flush_pre_occ: got %0d want 3", occupancy); end
    flush = 1'b1; out_ready = 1'b1; in_valid = 1'b1; in_data = 125'd203;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready: got %b want 0", in_ready); end
    @(posedge clk); #1 flush = 1'b0; in_valid = 1'b0;
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL flush_occ: got %0d want 0", occupancy); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_out_valid: got %b want 0", out_valid); end
    checks++; if (in_count !== 4'd3 || out_count !== 4'd0) begin errors++; $display("FAIL flush_counts: got %0d/%0d want 3/0", in_count, out_count); end
    in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    while (out_valid !== 1'b1 && waited < 10) begin
      @(posedge clk); #1 waited++;
    end
    checks++; if (waited != 2) begin errors++; $display("FAIL flush_latency: got %0d extra edges want 2", waited); end
    checks++; if (out_data !== 86'd203) begin errors++; $display("FAIL flush_next_data: got %0d want 203", out_data); end
    @(posedge clk); #1;
    checks++; if (in_count !== 4'd4 || out_count !== 4'd1) begin errors++; $display("FAIL flush_next_counts: got %0d/%0d want 4/1", in_count, out_count); end
  endtask

  task automatic test_wrap_and_rst();
    do_reset();
    stream_n(17, "wrap");
    checks++; if (in_count !== 4'd1) begin errors++; $display("FAIL wrap_in_count: got %0d want 1", in_count); end
    checks++; if (out_count !== 4'd1) begin errors++; $display("FAIL wrap_out_count: got %0d want 1", out_count); end
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = 125'(50 + i);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || occupancy !== 4'd3) begin errors++; $display("FAIL rst_pre: got v=%b occ=%0d want v=1 occ=3", out_valid, occupancy); end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); end
    checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL rst_mid_occ: got %0d want 0", occupancy); end
    checks++; if (in_count !== 4'd0 || out_count !== 4'd0) begin errors++; $display("FAIL rst_mid_counts: got %0d/%0d want 0/0", in_count, out_count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %b want 1", in_ready); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_flush();
    test_wrap_and_rst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
